// File: rtl/can_frame_tracker.sv
// CAN bit-level frame sequencer: removes stuff bits, tracks the current field,
// captures ID/IDE/RTR/DLC and raises the delimiter/EOF flags for form checking.
module can_frame_tracker (
   input  logic        SP,
   input  logic        reset,
   input  logic        RX,
   input  logic        ERR,
   output logic        F_CRC_D,
   output logic        F_ACK_D,
   output logic        F_EOF,
   output logic        STUFF_Error,
   output logic        FRAME_DONE,
   output logic [28:0] ID,
   output logic        IDE,
   output logic        RTR,
   output logic [3:0]  DLC
);
   // state      | meaning
   // S_IDLE     | bus idle, waiting for a dominant SOF
   // S_ID_A     | base identifier, 11 bits
   // S_SRR_RTR  | RTR (base) or SRR (extended)
   // S_IDE      | identifier extension bit
   // S_ID_B     | extended identifier, 18 bits
   // S_RTR_X    | RTR of an extended frame
   // S_R1       | reserved bit r1 (extended only)
   // S_R0       | reserved bit r0
   // S_DLC      | data length code, 4 bits
   // S_DATA     | data field, 8*n bits
   // S_CRC      | CRC sequence, 15 bits (+ trailing stuff bit if due)
   // S_CRC_DEL  | CRC delimiter
   // S_ACK_SLOT | ACK slot
   // S_ACK_DEL  | ACK delimiter
   // S_EOF      | end of frame, 7 bits
   // S_INTER    | intermission, 3 bits
   typedef enum logic [3:0] {
      S_IDLE, S_ID_A, S_SRR_RTR, S_IDE, S_ID_B, S_RTR_X, S_R1, S_R0,
      S_DLC, S_DATA, S_CRC, S_CRC_DEL, S_ACK_SLOT, S_ACK_DEL, S_EOF, S_INTER
   } state_t;

   state_t     state;
   logic [5:0] cnt;
   logic [2:0] run;
   logic       prev_bit;

   logic       in_window;
   logic       stuff_bit;
   logic       violation;
   logic       last_bit;
   logic [2:0] run_next;
   logic [3:0] dlc_next;
   logic [3:0] n_bytes;

   always_comb begin
      in_window = state inside {S_ID_A, S_SRR_RTR, S_IDE, S_ID_B, S_RTR_X,
                                S_R1, S_R0, S_DLC, S_DATA, S_CRC};
      stuff_bit = in_window && (run == 3'd5);
      violation = stuff_bit && (RX == prev_bit);
      last_bit  = (cnt == 6'd1);
      run_next  = (RX == prev_bit) ? run + 3'd1 : 3'd1;
      dlc_next  = {DLC[2:0], RX};
      if (RTR)
         n_bytes = 4'd0;
      else if (dlc_next > 4'd8)
         n_bytes = 4'd8;
      else
         n_bytes = dlc_next;
   end

   assign F_CRC_D = (state == S_CRC_DEL);
   assign F_ACK_D = (state == S_ACK_DEL);
   assign F_EOF   = (state == S_EOF);

   always_ff @(posedge SP) begin
      if (!reset) begin
         state       <= S_IDLE;
         cnt         <= 6'd0;
         run         <= 3'd0;
         prev_bit    <= 1'b0;
         STUFF_Error <= 1'b0;
         FRAME_DONE  <= 1'b0;
         ID          <= 29'd0;
         IDE         <= 1'b0;
         RTR         <= 1'b0;
         DLC         <= 4'd0;
      end else begin
         STUFF_Error <= 1'b0;
         FRAME_DONE  <= 1'b0;
         if (state != S_IDLE && ERR) begin
            state <= S_IDLE;
         end else if (violation) begin
            STUFF_Error <= 1'b1;
            state       <= S_IDLE;
         end else if (stuff_bit) begin
            run      <= 3'd1;
            prev_bit <= RX;
            // cnt==0 in CRC marks a stuff bit owed after the final CRC bit
            if (state == S_CRC && cnt == 6'd0) begin
               state <= S_CRC_DEL;
               cnt   <= 6'd1;
            end
         end else begin
            if (in_window) begin
               run      <= run_next;
               prev_bit <= RX;
            end
            if (state != S_IDLE)
               cnt <= cnt - 6'd1;
            case (state)
               S_IDLE: if (!RX) begin
                  state    <= S_ID_A;
                  cnt      <= 6'd11;
                  ID       <= 29'd0;
                  IDE      <= 1'b0;
                  RTR      <= 1'b0;
                  DLC      <= 4'd0;
                  run      <= 3'd1;
                  prev_bit <= 1'b0;
               end
               S_ID_A: begin
                  ID <= {ID[27:0], RX};
                  if (last_bit) begin state <= S_SRR_RTR; cnt <= 6'd1; end
               end
               S_SRR_RTR: begin
                  RTR <= RX;
                  if (last_bit) begin state <= S_IDE; cnt <= 6'd1; end
               end
               S_IDE: begin
                  IDE <= RX;
                  if (last_bit) begin
                     state <= RX ? S_ID_B : S_R0;
                     cnt   <= RX ? 6'd18 : 6'd1;
                  end
               end
               S_ID_B: begin
                  ID <= {ID[27:0], RX};
                  if (last_bit) begin state <= S_RTR_X; cnt <= 6'd1; end
               end
               S_RTR_X: begin
                  RTR <= RX;
                  if (last_bit) begin state <= S_R1; cnt <= 6'd1; end
               end
               S_R1: if (last_bit) begin state <= S_R0; cnt <= 6'd1; end
               S_R0: if (last_bit) begin state <= S_DLC; cnt <= 6'd4; end
               S_DLC: begin
                  DLC <= dlc_next;
                  if (last_bit) begin
                     if (n_bytes == 4'd0) begin
                        state <= S_CRC;
                        cnt   <= 6'd15;
                     end else begin
                        // eight bytes loads 0, which wraps to give 64 bits
                        state <= S_DATA;
                        cnt   <= {n_bytes[2:0], 3'b000};
                     end
                  end
               end
               S_DATA: if (last_bit) begin state <= S_CRC; cnt <= 6'd15; end
               S_CRC: if (last_bit) begin
                  if (run_next == 3'd5) begin
                     cnt <= 6'd0;
                  end else begin
                     state <= S_CRC_DEL;
                     cnt   <= 6'd1;
                  end
               end
               S_CRC_DEL:  if (last_bit) begin state <= S_ACK_SLOT; cnt <= 6'd1; end
               S_ACK_SLOT: if (last_bit) begin state <= S_ACK_DEL; cnt <= 6'd1; end
               S_ACK_DEL:  if (last_bit) begin state <= S_EOF; cnt <= 6'd7; end
               S_EOF: if (last_bit) begin
                  state      <= S_INTER;
                  cnt        <= 6'd3;
                  FRAME_DONE <= 1'b1;
               end
               S_INTER: if (last_bit) state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_can_frame_tracker.sv
// Bench for can_frame_tracker: builds stuffed CAN bit streams like a transmitter
// and checks per-bit flag responses through a scoreboard queue.
module tb_can_frame_tracker;
   logic        SP, reset, RX, ERR;
   logic        F_CRC_D, F_ACK_D, F_EOF, STUFF_Error, FRAME_DONE;
   logic [28:0] ID;
   logic        IDE, RTR;
   logic [3:0]  DLC;

   can_frame_tracker dut (
      .SP(SP), .reset(reset), .RX(RX), .ERR(ERR),
      .F_CRC_D(F_CRC_D), .F_ACK_D(F_ACK_D), .F_EOF(F_EOF),
      .STUFF_Error(STUFF_Error), .FRAME_DONE(FRAME_DONE),
      .ID(ID), .IDE(IDE), .RTR(RTR), .DLC(DLC)
   );

   initial SP = 1'b0;
   always #5 SP = ~SP;

   int         checks = 0;
   int         errors = 0;
   string      cur_tag = "init";
   logic [4:0] sb[$];
   bit         raw_q[$];
   bit         bits_q[$];
   logic [4:0] lab_q[$];
   int         crc_pos;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_next();
      logic [4:0] e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({cur_tag, "_flags"}, {27'd0, F_CRC_D, F_ACK_D, F_EOF, FRAME_DONE, STUFF_Error}, {27'd0, e});
      end
   endtask

   // expectation pushed is the DUT's flag state after it samples this bit
   task automatic send_bit(input logic b, input logic [4:0] e, input logic err);
      @(negedge SP);
      compare_next();
      RX  = b;
      ERR = err;
      sb.push_back(e);
   endtask

   task automatic flush();
      @(negedge SP);
      compare_next();
      RX  = 1'b1;
      ERR = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_flags"}, {27'd0, F_CRC_D, F_ACK_D, F_EOF, FRAME_DONE, STUFF_Error}, 32'd0);
      chk({tag, "_id"}, {3'd0, ID}, 32'd0);
      chk({tag, "_ide"}, {31'd0, IDE}, 32'd0);
      chk({tag, "_rtr"}, {31'd0, RTR}, 32'd0);
      chk({tag, "_dlc"}, {28'd0, DLC}, 32'd0);
   endtask

   task automatic chk_fields(input logic [28:0] id, input logic ide, input logic rtr, input logic [3:0] dlc);
      chk({cur_tag, "_id"}, {3'd0, ID}, {3'd0, id});
      chk({cur_tag, "_ide"}, {31'd0, IDE}, {31'd0, ide});
      chk({cur_tag, "_rtr"}, {31'd0, RTR}, {31'd0, rtr});
      chk({cur_tag, "_dlc"}, {28'd0, DLC}, {28'd0, dlc});
   endtask

   task automatic push_bits(input logic [63:0] v, input int w);
      for (int i = w - 1; i >= 0; i--) raw_q.push_back(v[i]);
   endtask

   task automatic build_frame(input logic [28:0] id, input logic ide, input logic rtr,
                              input logic [3:0] dlc, input logic [63:0] data, input logic [14:0] crc);
      int n, crc_raw, run;
      bit prev;
      raw_q.delete(); bits_q.delete(); lab_q.delete();
      push_bits(64'd0, 1);
      if (!ide) begin
         push_bits({53'd0, id[10:0]}, 11);
         push_bits({63'd0, rtr}, 1);
         push_bits(64'd0, 2);
      end else begin
         push_bits({53'd0, id[28:18]}, 11);
         push_bits(64'd3, 2);
         push_bits({46'd0, id[17:0]}, 18);
         push_bits({63'd0, rtr}, 1);
         push_bits(64'd0, 2);
      end
      push_bits({60'd0, dlc}, 4);
      n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
      if (n > 0) push_bits(data >> (64 - 8 * n), 8 * n);
      crc_raw = raw_q.size();
      push_bits({49'd0, crc}, 15);
      run = 0; prev = 1'b0;
      for (int i = 0; i < raw_q.size(); i++) begin
         bits_q.push_back(raw_q[i]); lab_q.push_back(5'd0);
         if (i == crc_raw) crc_pos = bits_q.size() - 1;
         if (i > 0 && raw_q[i] == prev) run++; else run = 1;
         prev = raw_q[i];
         if (run == 5) begin
            bits_q.push_back(!prev); lab_q.push_back(5'd0);
            prev = !prev; run = 1;
         end
      end
      bits_q.push_back(1'b1); lab_q.push_back(5'b10000);
      bits_q.push_back(1'b0); lab_q.push_back(5'b00000);
      bits_q.push_back(1'b1); lab_q.push_back(5'b01000);
      for (int i = 0; i < 7; i++) begin bits_q.push_back(1'b1); lab_q.push_back(5'b00100); end
      bits_q.push_back(1'b1); lab_q.push_back(5'b00010);
      for (int i = 0; i < 3; i++) begin bits_q.push_back(1'b1); lab_q.push_back(5'b00000); end
   endtask

   task automatic send_stream(input int start, input int n, input bit err_last);
      logic [4:0] e;
      bit er;
      for (int i = start; i < n; i++) begin
         er = err_last && (i == n - 1);
         e  = er ? 5'd0 : ((i + 1 < bits_q.size()) ? lab_q[i + 1] : 5'd0);
         send_bit(bits_q[i], e, er);
      end
   endtask

   initial begin
      reset = 1'b0; RX = 1'b1; ERR = 1'b0;
      repeat (3) @(negedge SP);
      check_zero("reset");
      reset = 1'b1;
      repeat (2) send_bit(1'b1, 5'd0, 1'b0);

      cur_tag = "base_123";
      build_frame(29'h123, 1'b0, 1'b0, 4'd1, 64'hA500_0000_0000_0000, 15'h001F);
      send_stream(0, bits_q.size(), 1'b0);
      flush();
      chk_fields(29'h123, 1'b0, 1'b0, 4'd1);

      cur_tag = "base_000";
      build_frame(29'h000, 1'b0, 1'b0, 4'd0, 64'd0, 15'h5555);
      send_stream(0, bits_q.size(), 1'b0);
      flush();
      chk_fields(29'h000, 1'b0, 1'b0, 4'd0);

      cur_tag = "stuff_viol";
      for (int i = 0; i < 6; i++) send_bit(1'b0, (i == 5) ? 5'b00001 : 5'd0, 1'b0);
      repeat (3) send_bit(1'b1, 5'd0, 1'b0);
      flush();

      cur_tag = "ext_rtr";
      build_frame(29'h1ABCDE12, 1'b1, 1'b1, 4'd2, 64'hFFFF_0000_0000_0000, 15'h3333);
      send_stream(0, bits_q.size(), 1'b0);
      flush();
      chk_fields(29'h1ABCDE12, 1'b1, 1'b1, 4'd2);

      cur_tag = "dlc_f";
      build_frame(29'h7F0, 1'b0, 1'b0, 4'hF, {$urandom, $urandom}, 15'h4C71);
      send_stream(0, bits_q.size(), 1'b0);
      flush();
      chk_fields(29'h7F0, 1'b0, 1'b0, 4'hF);

      cur_tag = "rst_mid";
      build_frame(29'h02A, 1'b0, 1'b0, 4'd8, {$urandom, $urandom}, 15'h1111);
      send_stream(0, 30, 1'b0);
      @(negedge SP);
      compare_next();
      reset = 1'b0; RX = 1'b1;
      @(negedge SP);
      check_zero("rst_mid");
      cur_tag = "after_rst";
      build_frame(29'h456, 1'b0, 1'b0, 4'd2, 64'hBEEF_0000_0000_0000, 15'h0F0F);
      reset = 1'b1;
      RX    = bits_q[0];
      sb.push_back(lab_q[1]);
      send_stream(1, bits_q.size(), 1'b0);
      flush();
      chk_fields(29'h456, 1'b0, 1'b0, 4'd2);

      cur_tag = "err_crc";
      build_frame(29'h5A5, 1'b0, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, 15'h2AAA);
      send_stream(0, crc_pos + 4, 1'b1);
      repeat (20) send_bit(1'b1, 5'd0, 1'b0);
      flush();
      chk_fields(29'h5A5, 1'b0, 1'b0, 4'd1);

      cur_tag = "err_stuff";
      for (int i = 0; i < 6; i++) send_bit(1'b0, 5'd0, (i == 5));
      repeat (3) send_bit(1'b1, 5'd0, 1'b0);
      flush();

      cur_tag = "recover";
      build_frame(29'h321, 1'b0, 1'b0, 4'd3, 64'h1234_5600_0000_0000, 15'h7E01);
      send_stream(0, bits_q.size(), 1'b0);
      flush();
      chk_fields(29'h321, 1'b0, 1'b0, 4'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
